// File: rtl/row_buff_ctrl.sv
// -----------------------------------------------------------------------------
// row_buff_ctrl
//   Sequencer for a three-row line buffer that feeds a 3-row sliding window.
//   Incoming beats are written round-robin into row buffers 0..2. Once two
//   full rows are stored, each new beat is also read out of the two older
//   buffers. The current beat is registered so that it lines up with the
//   one-cycle row-buffer read latency.
//
// Ports
//   clk, areset          clock, asynchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_data              input beat (also the write data of all row buffers)
//   flush                synchronous frame abort
//   wr_en[2:0]           per-buffer write enables (combinational)
//   rd_en[2:0]           per-buffer read enables (combinational)
//   buf_rstn             active-low pointer reset to the row buffers
//   top_sel, mid_sel     buffer holding window row r-2 / r-1
//   out_valid/out_ready  window handshake
//   out_bot              registered current-row beat
//   out_row, out_col     coordinates of out_bot
//   frame_done           one-cycle pulse after the last beat of a frame
// -----------------------------------------------------------------------------
module row_buff_ctrl #(
  parameter  int PIXELS_PER_BEAT = 16,
  parameter  int PIXEL_WIDTH     = 8,
  parameter  int IMAGE_DIM       = 512,
  localparam int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT,
  localparam int BEATS           = IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int CW              = $clog2(BEATS),
  localparam int RW              = $clog2(IMAGE_DIM)
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic [2:0]            wr_en,
  output logic [2:0]            rd_en,
  output logic                  buf_rstn,
  output logic [1:0]            top_sel,
  output logic [1:0]            mid_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic [RW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic                  frame_done
);

  typedef enum logic {FILL, STREAM} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] out_bot_q, out_bot_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic [CW-1:0]         out_col_q, out_col_d;
  logic [1:0]            top_sel_q, top_sel_d;
  logic [1:0]            mid_sel_q, mid_sel_d;
  logic                  rst_done_q, rst_done_d;

  logic       accept;
  logic       last_col;
  logic       last_row;
  logic [1:0] top_idx;
  logic [1:0] mid_idx;

  // Back-pressure only when a window is waiting and downstream is stalled.
  // Flush and reset both block acceptance so no buffer is touched then.
  assign in_ready = (~out_valid_q | out_ready) & ~flush & ~areset;
  assign accept   = in_valid & in_ready;

  assign last_col = (col_q == CW'(BEATS - 1));
  assign last_row = (row_q == RW'(IMAGE_DIM - 1));

  // The two buffers not being written hold the previous two rows, oldest
  // first in rotation order after the write buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    top_idx = 2'd1;
    mid_idx = 2'd2;
    case (wr_idx_q)
      2'd1:    begin top_idx = 2'd2; mid_idx = 2'd0; end
      2'd2:    begin top_idx = 2'd0; mid_idx = 2'd1; end
      default: begin top_idx = 2'd1; mid_idx = 2'd2; end
    endcase
  end

  assign wr_en = accept ? (3'b001 << wr_idx_q) : 3'b000;
  assign rd_en = (accept && state_q == STREAM)
               ? ((3'b001 << top_idx) | (3'b001 << mid_idx)) : 3'b000;

  // Pointer reset is held through reset and the first clock after it, and
  // for the cycle a flush is presented.
  assign buf_rstn = rst_done_q & ~flush;

  always_comb begin
    // NOTE: combinational next-state logic uses blocking '='; the flops use '<='.
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wr_idx_d     = wr_idx_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    out_bot_d    = out_bot_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    top_sel_d    = top_sel_q;
    mid_sel_d    = mid_sel_q;
    rst_done_d   = 1'b1;

    if (flush) begin
      state_d     = FILL;
      col_d       = '0;
      row_d       = '0;
      wr_idx_d    = 2'd0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
        if (state_q == STREAM) begin
          out_bot_d   = in_data;
          out_row_d   = row_q;
          out_col_d   = col_q;
          top_sel_d   = top_idx;
          mid_sel_d   = mid_idx;
          out_valid_d = 1'b1;
        end

        if (!last_col) begin
          col_d = col_q + CW'(1);
        end else begin
          col_d = '0;
          if (last_row) begin
            // Final beat of the frame: rewind everything for the next one.
            row_d        = '0;
            wr_idx_d     = 2'd0;
            state_d      = FILL;
            frame_done_d = 1'b1;
          end else begin
            row_d    = row_q + RW'(1);
            wr_idx_d = (wr_idx_q == 2'd2) ? 2'd0 : wr_idx_q + 2'd1;
            if (row_q == RW'(1)) state_d = STREAM;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      wr_idx_q     <= 2'd0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_bot_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      top_sel_q    <= 2'd0;
      mid_sel_q    <= 2'd0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_idx_q     <= wr_idx_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_bot_q    <= out_bot_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      top_sel_q    <= top_sel_d;
      mid_sel_q    <= mid_sel_d;
      rst_done_q   <= rst_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_bot    = out_bot_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign top_sel    = top_sel_q;
  assign mid_sel    = mid_sel_q;

endmodule
